obi_dual_mem_arbiter: RTL



---
 rtl/obi_dual_mem_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/obi_dual_mem_arbiter.sv
// obi_dual_mem_arbiter: round-robin arbiter of two OBI masters onto one slave, one outstanding transaction, response watchdog
module obi_dual_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    m0_req_i,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic                    m0_gnt_o,
   output logic                    m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   output logic                    m0_err_o,
   input  logic                    m1_req_i,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic                    m1_gnt_o,
   output logic                    m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   output logic                    m1_err_o,
   output logic                    s_req_o,
   output logic [ADDR_WIDTH-1:0]   s_addr_o,
   output logic                    s_we_o,
   output logic [DATA_WIDTH/8-1:0] s_be_o,
   output logic [DATA_WIDTH-1:0]   s_wdata_o,
   input  logic                    s_gnt_i,
   input  logic                    s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   s_rdata_i
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
   state_t state, state_nx;
   logic prio, prio_nx, owner, owner_nx;
   logic [CW-1:0] wdog, wdog_nx;
   logic winner, sel, sel_req, timeout, resp, gnt, data_ok;
   always_comb begin
      winner   = m1_req_i & (~m0_req_i | prio);
      sel      = (state == IDLE) ? winner : owner;
      sel_req  = sel ? m1_req_i : m0_req_i;
      timeout  = (state == WAIT) && (wdog == CW'(TIMEOUT - 1));
      resp     = (state == WAIT) && (s_rvalid_i || timeout);
      gnt      = rst_ni && (state != WAIT) && sel_req && s_gnt_i;
      data_ok  = resp && s_rvalid_i;
      state_nx = state;
      prio_nx  = prio;
      owner_nx = owner;
      wdog_nx  = wdog;
      if (state == IDLE && (m0_req_i || m1_req_i)) begin
         owner_nx = winner;
         state_nx = s_gnt_i ? WAIT : HOLD;
      end
      if (state == HOLD) state_nx = !sel_req ? IDLE : (s_gnt_i ? WAIT : HOLD);
      if (state == WAIT) begin
         wdog_nx = resp ? '0 : wdog + 1'b1;
         if (resp) begin
            prio_nx  = ~owner;
            state_nx = IDLE;
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         prio  <= 1'b0;
         owner <= 1'b0;
         wdog  <= '0;
      end else begin
         state <= state_nx;
         prio  <= prio_nx;
         owner <= owner_nx;
         wdog  <= wdog_nx;
      end
   end
   // Outputs are forced low while reset is held, even though inputs may toggle.
   assign s_req_o     = rst_ni && (state != WAIT) && sel_req;
   assign s_addr_o    = !rst_ni ? '0 : (sel ? m1_addr_i : m0_addr_i);
   assign s_we_o      = rst_ni && (sel ? m1_we_i : m0_we_i);
   assign s_be_o      = !rst_ni ? '0 : (sel ? m1_be_i : m0_be_i);
   assign s_wdata_o   = !rst_ni ? '0 : (sel ? m1_wdata_i : m0_wdata_i);
   assign m0_gnt_o    = gnt && !sel;
   assign m1_gnt_o    = gnt && sel;
   assign m0_rvalid_o = resp && !owner;
   assign m1_rvalid_o = resp && owner;
   assign m0_err_o    = resp && !s_rvalid_i && !owner;
   assign m1_err_o    = resp && !s_rvalid_i && owner;
   assign m0_rdata_o  = (data_ok && !owner) ? s_rdata_i : '0;
   assign m1_rdata_o  = (data_ok && owner) ? s_rdata_i : '0;
endmodule
